// File: rtl/wb_core_2_pkg.sv
// Shared definitions for the Wishbone initiator, the register-file slave and
// the bench interface: bus width defaults, the initiator FSM state encoding,
// and packed command/response records.
package wb_core_2_pkg;

    localparam int WB_ADDR_WIDTH = 16;
    localparam int WB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } wb_mst_state_e;

    typedef struct packed {
        logic                     we;
        logic [WB_ADDR_WIDTH-1:0] adr;
        logic [WB_DATA_WIDTH-1:0] dat;
    } wb_cmd_t;

    typedef struct packed {
        logic [WB_DATA_WIDTH-1:0] dat;
        logic                     err;
        logic                     timeout;
    } wb_rsp_t;

endpackage

// File: rtl/wb_master_timeout.sv
// Saturating cycle counter that bounds how long the initiator may sit in
// REQ/WAIT.
//   clk_i     : system clock
//   rst_i     : synchronous, active-low reset
//   clr_i     : restart the count (command accepted)
//   en_i      : count this cycle (transaction in flight)
//   expired_o : the count reaches TIMEOUT_CYCLES on the coming edge
module wb_master_timeout #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Flag one edge early so the FSM can abort on the same edge the count
    // reaches the limit.
    assign expired_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/wb_master_core.sv
// Wishbone B4 pipelined single-transfer initiator. Takes one command on a
// valid/ready port, runs one bus cycle (honouring stall), waits for ack/err
// or a timeout, then presents one response on a valid/ready port.
//   clk_i, rst_i            : clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o : command handshake
//   cmd_we_i/adr_i/dat_i    : command fields
//   rsp_valid_o/rsp_ready_i : response handshake
//   rsp_dat_o/err_o/timeout_o : response fields
//   cyc_o..dat_o            : registered Wishbone outputs
//   dat_i, ack_i, err_i, stall_i : Wishbone inputs
module wb_master_core
    import wb_core_2_pkg::*;
#(
    parameter int ADDR_WIDTH     = WB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,
    input  logic                  err_i,
    input  logic                  stall_i
);

    wb_mst_state_e         state_q;
    logic                  cyc_q;
    logic                  stb_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;
    logic [DATA_WIDTH-1:0] rsp_dat_q;

    logic                  accept;
    logic                  busy;
    logic                  bus_rsp;
    logic                  expired;
    logic                  finish;
    logic                  rsp_err_d;
    logic                  rsp_timeout_d;
    logic [DATA_WIDTH-1:0] rsp_dat_d;

    assign cmd_ready_o = (state_q == IDLE) && rst_i;
    assign accept      = cmd_ready_o && cmd_valid_i;
    assign busy        = (state_q == REQ) || (state_q == WAIT);

    wb_master_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (accept),
        .en_i     (busy),
        .expired_o(expired)
    );

    // A slave answer only counts once the request has been taken: in WAIT,
    // or in REQ on a non-stalled edge. Answers while stalled, in IDLE or in
    // RSP are ignored. A real answer beats a simultaneous timeout, and err
    // beats ack.
    always_comb begin
        bus_rsp = 1'b0;
        if (state_q == WAIT) begin
            bus_rsp = ack_i || err_i;
        end else if ((state_q == REQ) && !stall_i) begin
            bus_rsp = ack_i || err_i;
        end
        finish        = bus_rsp || expired;
        rsp_err_d     = bus_rsp ? err_i : 1'b1;
        rsp_timeout_d = !bus_rsp;
        rsp_dat_d     = '0;
        if (bus_rsp && !err_i && !we_q) begin
            rsp_dat_d = dat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q       <= IDLE;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            we_q          <= 1'b0;
            adr_q         <= '0;
            dat_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_dat_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q    <= cmd_we_i;
                        adr_q   <= cmd_adr_i;
                        dat_q   <= cmd_dat_i;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ, WAIT: begin
                    if (finish) begin
                        cyc_q         <= 1'b0;
                        stb_q         <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= rsp_err_d;
                        rsp_timeout_q <= rsp_timeout_d;
                        rsp_dat_q     <= rsp_dat_d;
                        state_q       <= RSP;
                    end else if ((state_q == REQ) && !stall_i) begin
                        stb_q   <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cyc_o         = cyc_q;
    assign stb_o         = stb_q;
    assign we_o          = we_q;
    assign adr_o         = adr_q;
    assign dat_o         = dat_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign rsp_dat_o     = rsp_dat_q;

endmodule

// File: tb/tb_wb_master_core.sv
module tb_wb_master_core;
    import wb_core_2_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_we_i;
    logic [AW-1:0] cmd_adr_i;
    logic [DW-1:0] cmd_dat_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_dat_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;
    logic          cyc_o;
    logic          stb_o;
    logic          we_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o;
    logic [DW-1:0] dat_i;
    logic          ack_i;
    logic          err_i;
    logic          stall_i;

    int total = 0;
    int bad   = 0;

    // Behavioural slave: 16 word registers at 0x00..0x3C, err beyond.
    logic [DW-1:0] mem [16];

    always #5 clk_i = ~clk_i;

    wb_master_core #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_we_i     (cmd_we_i),
        .cmd_adr_i    (cmd_adr_i),
        .cmd_dat_i    (cmd_dat_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_dat_o    (rsp_dat_o),
        .rsp_err_o    (rsp_err_o),
        .rsp_timeout_o(rsp_timeout_o),
        .cyc_o        (cyc_o),
        .stb_o        (stb_o),
        .we_o         (we_o),
        .adr_o        (adr_o),
        .dat_o        (dat_o),
        .dat_i        (dat_i),
        .ack_i        (ack_i),
        .err_i        (err_i),
        .stall_i      (stall_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // kind: 0 = slave answers normally (ack in range, err beyond),
    //       1 = slave silent, 2 = slave drives ack and err together.
    // resp_edge counts rising edges after the accept edge.
    task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wdat,
                           input int nstall, input int nwait, input int kind,
                           input int rdly, input bit late);
        int            idx;
        bit            in_range;
        int            resp_edge;
        bit            to;
        int            end_k;
        bit            exp_err;
        logic [DW-1:0] exp_dat;
        bit            give_ack;
        bit            give_err;

        idx       = int'(adr[5:2]);
        in_range  = (adr < 16'h0040);
        resp_edge = nstall + 1 + nwait;
        to        = (kind == 1) || (resp_edge > TO);
        end_k     = to ? TO : resp_edge;
        give_ack  = !to && ((kind == 2) || ((kind == 0) && in_range));
        give_err  = !to && ((kind == 2) || ((kind == 0) && !in_range));
        exp_err   = to || give_err;
        exp_dat   = (exp_err || we) ? '0 : mem[idx];

        chk("cmd_ready_idle", 64'(cmd_ready_o), 64'(1));
        cmd_valid_i = 1'b1;
        cmd_we_i    = we;
        cmd_adr_i   = adr;
        cmd_dat_i   = wdat;
        tick();
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'($urandom);
        cmd_adr_i   = AW'($urandom);
        cmd_dat_i   = $urandom;

        for (int k = 1; k <= end_k; k++) begin
            stall_i = (k <= nstall);
            ack_i   = give_ack && (k == resp_edge);
            err_i   = give_err && (k == resp_edge);
            // answers during stall are protocol violations and must be ignored
            if ((k <= nstall) && ($urandom_range(0, 3) == 0)) ack_i = 1'b1;
            dat_i   = (give_ack && (k == resp_edge) && !we) ? mem[idx] : $urandom;
            chk("cyc_busy", 64'(cyc_o), 64'(1));
            chk("stb_busy", 64'(stb_o), 64'(k <= nstall + 1));
            chk("adr_hold", 64'(adr_o), 64'(adr));
            chk("dat_hold", 64'(dat_o), 64'(wdat));
            chk("we_hold", 64'(we_o), 64'(we));
            chk("cmd_ready_busy", 64'(cmd_ready_o), 64'(0));
            chk("rsp_valid_busy", 64'(rsp_valid_o), 64'(0));
            tick();
        end
        stall_i = 1'b0;
        ack_i   = 1'b0;
        err_i   = 1'b0;
        if (give_ack && !give_err && we) mem[idx] = wdat;

        for (int d = 0; d <= rdly; d++) begin
            if (late) begin
                ack_i = 1'($urandom);
                err_i = 1'($urandom);
                dat_i = $urandom;
            end
            chk("rsp_valid", 64'(rsp_valid_o), 64'(1));
            chk("cyc_rsp", 64'(cyc_o), 64'(0));
            chk("stb_rsp", 64'(stb_o), 64'(0));
            chk("rsp_err", 64'(rsp_err_o), 64'(exp_err));
            chk("rsp_timeout", 64'(rsp_timeout_o), 64'(to));
            chk("rsp_dat", 64'(rsp_dat_o), 64'(exp_dat));
            chk("cmd_ready_rsp", 64'(cmd_ready_o), 64'(0));
            rsp_ready_i = (d == rdly);
            tick();
        end
        rsp_ready_i = 1'b0;
        ack_i       = 1'b0;
        err_i       = 1'b0;
        chk("rsp_valid_done", 64'(rsp_valid_o), 64'(0));
        chk("cyc_idle", 64'(cyc_o), 64'(0));
        chk("cmd_ready_back", 64'(cmd_ready_o), 64'(1));

        if (late) begin
            ack_i = 1'b1;
            err_i = 1'b1;
            tick();
            ack_i = 1'b0;
            err_i = 1'b0;
            chk("late_cyc_idle", 64'(cyc_o), 64'(0));
            chk("late_rsp_idle", 64'(rsp_valid_o), 64'(0));
            chk("late_ready", 64'(cmd_ready_o), 64'(1));
        end
    endtask

    initial begin
        logic [AW-1:0] radr;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        rst_i       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_we_i    = 1'b0;
        cmd_adr_i   = '0;
        cmd_dat_i   = '0;
        rsp_ready_i = 1'b0;
        dat_i       = '0;
        ack_i       = 1'b0;
        err_i       = 1'b0;
        stall_i     = 1'b0;

        // reset state
        repeat (3) @(negedge clk_i);
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'(0));
        chk("rst_cyc", 64'(cyc_o), 64'(0));
        chk("rst_stb", 64'(stb_o), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("rst_adr", 64'(adr_o), 64'(0));
        chk("rst_rsp_dat", 64'(rsp_dat_o), 64'(0));
        rst_i = 1'b1;
        #1;
        chk("post_rst_ready", 64'(cmd_ready_o), 64'(1));
        tick();

        // directed plan
        run_txn(1'b1, 16'h0004, 32'hDEADBEEF, 0, 1, 0, 0, 1'b0);
        run_txn(1'b0, 16'h0004, 32'h12345678, 0, 1, 0, 1, 1'b0);
        chk("readback_model", 64'(mem[1]), 64'(32'hDEADBEEF));
        run_txn(1'b0, 16'h0004, 32'h0BADF00D, 3, 1, 0, 0, 1'b0);
        run_txn(1'b1, 16'h0040, 32'hCAFEF00D, 0, 1, 0, 0, 1'b0);
        run_txn(1'b0, 16'h0008, 32'h0, 0, 0, 1, 1, 1'b1);
        run_txn(1'b0, 16'h0004, 32'h0, 0, 2, 0, 0, 1'b0);
        // zero-wait back-to-back
        run_txn(1'b1, 16'h000C, 32'hA5A5A5A5, 0, 0, 0, 0, 1'b0);
        run_txn(1'b0, 16'h000C, 32'h0, 0, 0, 0, 0, 1'b0);
        // ack+err together, and timeout boundaries
        run_txn(1'b0, 16'h0010, 32'h0, 1, 1, 2, 0, 1'b0);
        run_txn(1'b0, 16'h0004, 32'h0, 14, 0, 0, 0, 1'b0);
        run_txn(1'b0, 16'h0004, 32'h0, 13, 2, 0, 0, 1'b1);
        run_txn(1'b1, 16'h0014, 32'h77777777, 20, 0, 0, 0, 1'b0);

        // reset while waiting for the slave
        cmd_valid_i = 1'b1;
        cmd_we_i    = 1'b1;
        cmd_adr_i   = 16'h0008;
        cmd_dat_i   = 32'h55AA55AA;
        tick();
        cmd_valid_i = 1'b0;
        tick();
        chk("wait_cyc", 64'(cyc_o), 64'(1));
        chk("wait_stb", 64'(stb_o), 64'(0));
        rst_i = 1'b0;
        tick();
        chk("midrst_cyc", 64'(cyc_o), 64'(0));
        chk("midrst_stb", 64'(stb_o), 64'(0));
        chk("midrst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("midrst_cmd_ready", 64'(cmd_ready_o), 64'(0));
        chk("midrst_adr", 64'(adr_o), 64'(0));
        chk("midrst_dat", 64'(dat_o), 64'(0));
        rst_i = 1'b1;
        #1;
        chk("midrst_ready_back", 64'(cmd_ready_o), 64'(1));
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        repeat (3) begin
            chk("midrst_no_rsp", 64'(rsp_valid_o), 64'(0));
            chk("midrst_no_cyc", 64'(cyc_o), 64'(0));
            tick();
        end
        run_txn(1'b0, 16'h0008, 32'h0, 1, 1, 0, 0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0) radr = 16'h0040 + AW'(4 * $urandom_range(0, 15));
            else                           radr = AW'(4 * $urandom_range(0, 15));
            run_txn(1'($urandom), radr, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 4),
                    ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0),
                    $urandom_range(0, 2), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
